axi4lite_regfile_slave: RTL and testbench
=========================================

# axi4lite_regfile_slave

AXI4-Lite slave holding a bank of NREGS software-visible registers. It sits directly downstream of the Wishbone-to-AXI4-Lite bridge and terminates its master port (aw/w/b/ar/r channels) inside a peripheral. Register contents are exported flat to the peripheral's datapath. The block allows one outstanding transaction per direction, accepts AW and W in any order, and answers SLVERR for addresses outside the bank.

## Interface
- DW, 32, data width in bits; 32 or 64.
- AW, 32, address width in bits.
- NREGS, 16, number of DW-bit registers; power of two, at least 2.
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- s_axi_awaddr / s_axi_awprot / s_axi_awvalid  in  AW / 3 / 1  write address; prot ignored.
- s_axi_awready  out  1  write address accept.
- s_axi_wdata / s_axi_wstrb / s_axi_wvalid  in  DW / DW/8 / 1  write data, byte strobes.
- s_axi_wready  out  1  write data accept.
- s_axi_bresp / s_axi_bvalid  out  2 / 1  write response.
- s_axi_bready  in  1  write response accept.
- s_axi_araddr / s_axi_arprot / s_axi_arvalid  in  AW / 3 / 1  read address; prot ignored.
- s_axi_arready  out  1  read address accept.
- s_axi_rdata / s_axi_rresp / s_axi_rvalid  out  DW / 2 / 1  read data and response.
- s_axi_rready  in  1  read data accept.
- regs_o  out  NREGS*DW  register contents; reg k is at bits [k*DW +: DW].

## Operation
- Word index is addr[log2(DW/8) +: log2(NREGS)]. An address is in range when addr < NREGS*DW/8. Low address bits below the word are ignored.
- Write path: separate held flags aw_held and w_held, each with its own latched address or data+strobe.
  - awready = !aw_held && !bvalid && !rst; wready = !w_held && !bvalid && !rst.
  - A handshake on either channel sets its flag. AW and W may complete in the same cycle or in either order.
- Commit: on the edge where both items are available (held, or handshaking that cycle):
  - In range: the selected register is updated per byte lane where wstrb is 1, and bresp=OKAY.
  - Out of range: no register changes, and bresp=SLVERR.
  - At the same edge both flags clear and bvalid is set.
- bvalid/bresp stay stable until bready. AW/W are not accepted while bvalid is 1.
- Read path: arready = !rvalid && !rst.
  - On an AR handshake, rdata is registered and rvalid is set. In range gives the register value and OKAY; out of range gives 0 and SLVERR.
  - rvalid, rdata and rresp stay stable until rready.
- Read and write paths are independent and may be active at the same time.
- Resp codes: OKAY=2'b00, SLVERR=2'b10. EXOKAY and DECERR are never produced.

## Timing
- Reset values: all registers 0, regs_o 0, bvalid 0, rvalid 0, bresp 0, rresp 0, rdata 0. All ready outputs are 0 during reset and 1 in the first cycle after wb_rst_i falls.
- Write latency: if the later of the AW/W handshakes is in cycle N, bvalid rises in N+1 and regs_o shows the new value from N+1.
- Read latency: AR handshake in cycle N gives rvalid in N+1.
- Back-to-back writes: a B handshake in cycle M lets awready/wready rise in M+1. Peak throughput is one write per 2 cycles.
- Back-to-back reads: same pattern; peak throughput is one read per 2 cycles.
- Read and write to the same register at the same edge: the read returns the old value.
- Reset mid-transaction drops all held items and pending responses. No response is issued for them.

## Structure
- The shared package axi4lite_pkg holds:
  - resp constants: RESP_OKAY and RESP_SLVERR;
  - the function clog2 used for the index width;
  - the function apply_wstrb(old, new, strb).
- One sub-module, axi4lite_wr_join. It holds the AW/W held flags and latches, and gives a one-cycle commit pulse with the joined address, data and strobe.
- The read path and the register array live in the top module.

## Test plan
- AW and W together with addr 0x8, data 0xDEADBEEF, strb 0xF -> bvalid next cycle, bresp=00, regs_o reg2=0xDEADBEEF; then AR 0x8 -> rdata 0xDEADBEEF, rresp=00 one cycle later.
- W first, AW 3 cycles later (addr 0x0, data 0x11223344, strb 0x5) on reg0=0xFFFFFFFF -> wready low after W accepted; bvalid one cycle after AW; reg0=0xFF22FF44.
- Write to addr 0x40 with NREGS=16, DW=32 -> bresp=10 and no register changes; read of 0x44 -> rdata 0, rresp=10.
- bready held low 5 cycles -> bvalid/bresp stable, awready and wready stay 0; the next AW/W is accepted the cycle after the B handshake.
- Write commit to reg1 at the same edge as an AR to 0x4 (old value 0x5) -> rdata=0x5; a following read returns the new value.
- Assert wb_rst_i while aw_held=1 and rvalid=1 -> all outputs return to their reset values; a write issued after reset completes normally.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: shared AXI4-Lite response codes and register-update helpers
package axi4lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Sized for the widest supported bus; callers zero-extend and truncate.
    function automatic logic [63:0] apply_wstrb(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] strb);
        logic [63:0] res = old;
        for (int i = 0; i < 8; i++) if (strb[i]) res[i*8 +: 8] = nw[i*8 +: 8];
        return res;
    endfunction
endpackage

// File: rtl/axi4lite_wr_join.sv
// axi4lite_wr_join: accepts AW and W in either order and emits a one-cycle commit with the joined beat
module axi4lite_wr_join #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   awaddr,
    input  logic            awvalid,
    output logic            awready,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic            wvalid,
    output logic            wready,
    input  logic            bvalid,
    output logic            commit,
    output logic [AW-1:0]   addr,
    output logic [DW-1:0]   data,
    output logic [DW/8-1:0] strb
);
    logic            aw_held, w_held, aw_hs, w_hs;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic [DW/8-1:0] strb_q;

    always_comb begin
        awready = !aw_held && !bvalid && !rst;
        wready  = !w_held && !bvalid && !rst;
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        commit  = (aw_held || aw_hs) && (w_held || w_hs);
        addr    = aw_held ? addr_q : awaddr;
        data    = w_held ? data_q : wdata;
        strb    = w_held ? strb_q : wstrb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                addr_q  <= awaddr;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                data_q <= wdata;
                strb_q <= wstrb;
            end
        end
    end
endmodule

// File: rtl/axi4lite_regfile_slave.sv
// axi4lite_regfile_slave: AXI4-Lite register bank with flat export, one outstanding read and write
module axi4lite_regfile_slave
    import axi4lite_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int NREGS = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [AW-1:0]       s_axi_awaddr,
    input  logic [2:0]          s_axi_awprot,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DW-1:0]       s_axi_wdata,
    input  logic [DW/8-1:0]     s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [AW-1:0]       s_axi_araddr,
    input  logic [2:0]          s_axi_arprot,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DW-1:0]       s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [NREGS*DW-1:0] regs_o
);
    localparam int BW = clog2(DW/8);
    localparam int IW = clog2(NREGS);
    localparam logic [AW-1:0] LIMIT = AW'(NREGS*DW/8);

    logic [DW-1:0]   regs [NREGS];
    logic            commit, wr_ok, rd_ok, ar_hs, unused;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata_j;
    logic [DW/8-1:0] wstrb_j;
    logic [IW-1:0]   widx, ridx;

    axi4lite_wr_join #(.AW(AW), .DW(DW)) u_join (
        .clk(wb_clk_i), .rst(wb_rst_i),
        .awaddr(s_axi_awaddr), .awvalid(s_axi_awvalid), .awready(s_axi_awready),
        .wdata(s_axi_wdata), .wstrb(s_axi_wstrb), .wvalid(s_axi_wvalid), .wready(s_axi_wready),
        .bvalid(s_axi_bvalid),
        .commit(commit), .addr(waddr), .data(wdata_j), .strb(wstrb_j)
    );

    assign unused = ^{s_axi_awprot, s_axi_arprot};

    always_comb begin
        wr_ok         = waddr < LIMIT;
        rd_ok         = s_axi_araddr < LIMIT;
        widx          = waddr[BW +: IW];
        ridx          = s_axi_araddr[BW +: IW];
        s_axi_arready = !s_axi_rvalid && !wb_rst_i;
        ar_hs         = s_axi_arvalid && s_axi_arready;
    end

    // Read data is sampled from the pre-edge array, so a same-edge write is not visible.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rdata  <= '0;
        end else begin
            if (commit) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok) regs[widx] <= DW'(apply_wstrb(64'(regs[widx]), 64'(wdata_j), 8'(wstrb_j)));
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            if (ar_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                s_axi_rdata  <= rd_ok ? regs[ridx] : '0;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_out
        assign regs_o[k*DW +: DW] = regs[k];
    end
endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// tb_axi4lite_regfile_slave: directed stimulus with a queue scoreboard checked by a response monitor
module tb_axi4lite_regfile_slave;
    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i = 1'b1;
    logic [31:0]  s_axi_awaddr = '0;
    logic [2:0]   s_axi_awprot = '0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata = '0;
    logic [3:0]   s_axi_wstrb = '0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b1;
    logic [31:0]  s_axi_araddr = '0;
    logic [2:0]   s_axi_arprot = '0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b1;
    logic [511:0] regs_o;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic [1:0] exp_b[$];
    rexp_t      exp_r[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [511:0] exp_flat;

    axi4lite_regfile_slave #(.DW(32), .AW(32), .NREGS(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .regs_o(regs_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor: a handshake seen at the negedge completes on the following posedge.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                else chk("bresp", 64'(s_axi_bresp), 64'(exp_b.pop_front()));
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    rexp_t e;
                    e = exp_r.pop_front();
                    chk("rdata", 64'(s_axi_rdata), 64'(e.d));
                    chk("rresp", 64'(s_axi_rresp), 64'(e.r));
                end
            end
        end
    end

    task automatic do_aw(input logic [31:0] a);
        bit ok = 0;
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge wb_clk_i);
            ok = s_axi_awready;
        end
        if (!ok) chk("aw_timeout", 1, 0);
        else @(posedge wb_clk_i);
        #1 s_axi_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        s_axi_wvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge wb_clk_i);
            ok = s_axi_wready;
        end
        if (!ok) chk("w_timeout", 1, 0);
        else @(posedge wb_clk_i);
        #1 s_axi_wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a);
        bit ok = 0;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge wb_clk_i);
            ok = s_axi_arready;
        end
        if (!ok) chk("ar_timeout", 1, 0);
        else @(posedge wb_clk_i);
        #1 s_axi_arvalid = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
        exp_b.push_back(r);
        fork
            do_aw(a);
            do_w(d, s);
        join
    endtask

    task automatic read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        exp_r.push_back('{d: d, r: r});
        do_ar(a);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("rst_awready", 64'(s_axi_awready), 0);
        chk("rst_wready", 64'(s_axi_wready), 0);
        chk("rst_arready", 64'(s_axi_arready), 0);
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("post_rst_awready", 64'(s_axi_awready), 1);
        chk("post_rst_wready", 64'(s_axi_wready), 1);
        chk("post_rst_arready", 64'(s_axi_arready), 1);
        chk("post_rst_bvalid", 64'(s_axi_bvalid), 0);
        chk("post_rst_rvalid", 64'(s_axi_rvalid), 0);
        chk("post_rst_rdata", 64'(s_axi_rdata), 0);
        chk("post_rst_regs", 64'(regs_o == '0), 1);
        idle(1);

        // AW and W together, then read back
        write(32'h8, 32'hDEADBEEF, 4'hF, 2'b00);
        @(negedge wb_clk_i);
        chk("t1_bvalid", 64'(s_axi_bvalid), 1);
        chk("t1_reg2", 64'(regs_o[2*32 +: 32]), 64'hDEADBEEF);
        idle(1);
        read(32'h8, 32'hDEADBEEF, 2'b00);
        @(negedge wb_clk_i);
        chk("t1_rvalid", 64'(s_axi_rvalid), 1);
        idle(2);

        // W first, AW later, partial strobe
        write(32'h0, 32'hFFFFFFFF, 4'hF, 2'b00);
        idle(2);
        exp_b.push_back(2'b00);
        do_w(32'h11223344, 4'h5);
        @(negedge wb_clk_i);
        chk("t2_wready_low", 64'(s_axi_wready), 0);
        chk("t2_awready_high", 64'(s_axi_awready), 1);
        chk("t2_no_bvalid", 64'(s_axi_bvalid), 0);
        idle(2);
        do_aw(32'h0);
        @(negedge wb_clk_i);
        chk("t2_bvalid", 64'(s_axi_bvalid), 1);
        chk("t2_reg0", 64'(regs_o[0 +: 32]), 64'hFF22FF44);
        idle(2);

        // Out-of-range write and read
        write(32'h40, 32'h12345678, 4'hF, 2'b10);
        idle(2);
        exp_flat = '0;
        exp_flat[0 +: 32]  = 32'hFF22FF44;
        exp_flat[64 +: 32] = 32'hDEADBEEF;
        chk("t3_regs_unchanged", 64'(regs_o == exp_flat), 1);
        read(32'h44, 32'h0, 2'b10);
        idle(2);

        // Stalled B channel
        s_axi_bready = 1'b0;
        write(32'h80, 32'h55AA55AA, 4'hF, 2'b10);
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i);
            chk("t4_bvalid_hold", 64'(s_axi_bvalid), 1);
            chk("t4_bresp_hold", 64'(s_axi_bresp), 2);
            chk("t4_awready_low", 64'(s_axi_awready), 0);
            chk("t4_wready_low", 64'(s_axi_wready), 0);
        end
        @(posedge wb_clk_i);
        #1 s_axi_bready = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("t4_awready_back", 64'(s_axi_awready), 1);
        chk("t4_wready_back", 64'(s_axi_wready), 1);
        chk("t4_bvalid_clear", 64'(s_axi_bvalid), 0);
        @(posedge wb_clk_i);
        #1;
        write(32'hC, 32'hA5A5A5A5, 4'hF, 2'b00);
        @(negedge wb_clk_i);
        chk("t4_reg3", 64'(regs_o[3*32 +: 32]), 64'hA5A5A5A5);
        idle(2);

        // Same-edge write and read of reg1
        write(32'h4, 32'h5, 4'hF, 2'b00);
        idle(3);
        exp_b.push_back(2'b00);
        exp_r.push_back('{d: 32'h5, r: 2'b00});
        fork
            do_aw(32'h4);
            do_w(32'h77, 4'hF);
            do_ar(32'h4);
        join
        @(negedge wb_clk_i);
        chk("t5_reg1", 64'(regs_o[1*32 +: 32]), 64'h77);
        idle(2);
        read(32'h4, 32'h77, 2'b00);
        idle(2);

        // Reset with a held AW and a pending read response
        do_aw(32'h10);
        s_axi_rready = 1'b0;
        do_ar(32'h0);
        @(negedge wb_clk_i);
        chk("t6_rvalid_pending", 64'(s_axi_rvalid), 1);
        chk("t6_awready_held", 64'(s_axi_awready), 0);
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("t6_rst_arready", 64'(s_axi_arready), 0);
        chk("t6_rst_wready", 64'(s_axi_wready), 0);
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        s_axi_rready = 1'b1;
        @(negedge wb_clk_i);
        chk("t6_rvalid", 64'(s_axi_rvalid), 0);
        chk("t6_bvalid", 64'(s_axi_bvalid), 0);
        chk("t6_rdata", 64'(s_axi_rdata), 0);
        chk("t6_rresp", 64'(s_axi_rresp), 0);
        chk("t6_regs", 64'(regs_o == '0), 1);
        chk("t6_awready", 64'(s_axi_awready), 1);
        chk("t6_wready", 64'(s_axi_wready), 1);
        chk("t6_arready", 64'(s_axi_arready), 1);
        idle(1);
        write(32'h14, 32'hCAFEF00D, 4'hF, 2'b00);
        @(negedge wb_clk_i);
        chk("t6_reg5", 64'(regs_o[5*32 +: 32]), 64'hCAFEF00D);
        chk("t6_reg4", 64'(regs_o[4*32 +: 32]), 64'h0);
        idle(2);
        read(32'h14, 32'hCAFEF00D, 2'b00);
        idle(4);

        chk("sb_b_drained", 64'(exp_b.size()), 0);
        chk("sb_r_drained", 64'(exp_r.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
